// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared core types and constants
// Fetch buffer entry layout and architectural constants.
package riscv_pkg;

   localparam int XLEN = 32;
   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of fetch entries
// Flush wins over push/pop; a push into a full FIFO is accepted only alongside a pop.
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t push_data,
   output logic         full,
   output logic         empty,
   output fetch_entry_t head
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   fetch_entry_t  mem [DEPTH];
   logic          do_push;
   logic          do_pop;

   assign full    = (count == DEPTH_CNT);
   assign empty   = (count == '0);
   assign do_pop  = pop & !empty;
   assign do_push = push & (!full | do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: the head is masked whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch: PC, imem read, buffered decode handshake
// Redirects from EX flush the buffer and restart fetch at the aligned target.
module instr_fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   logic [31:0]  pc;
   logic         pop;
   logic         fetch;
   logic         full;
   logic         empty;
   fetch_entry_t head;
   fetch_entry_t push_data;

   assign imem_addr = pc;
   assign if_valid  = !empty & !redirect_valid;
   assign pop       = if_valid & if_ready;
   // A full buffer still fetches when decode drains the head this cycle.
   assign fetch     = !redirect_valid & (!full | pop);
   assign push_data = '{pc: pc, instr: imem_rdata};

   assign if_instr    = empty ? 32'h0 : head.instr;
   assign if_pc       = empty ? 32'h0 : head.pc;
   assign if_pc_plus4 = empty ? 32'h0 : head.pc + 32'd4;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (redirect_valid) begin
         pc <= {redirect_pc[31:2], 2'b00};
      end else if (fetch) begin
         pc <= pc + 32'd4;
      end
   end

   fetch_fifo #(
      .DEPTH(BUF_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (fetch),
      .pop      (pop),
      .flush    (redirect_valid),
      .push_data(push_data),
      .full     (full),
      .empty    (empty),
      .head     (head)
   );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic        if_ready = 1'b0;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;

   int tests = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Memory model: word i holds 0xA000_0000 + i.
   assign imem_rdata = 32'hA000_0000 + {2'b00, imem_addr[31:2]};

   instr_fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .BUF_DEPTH(2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .if_valid      (if_valid),
      .if_ready      (if_ready),
      .if_instr      (if_instr),
      .if_pc         (if_pc),
      .if_pc_plus4   (if_pc_plus4),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      if_ready = 1'b1;
      #12;
      check("rst_valid", {31'h0, if_valid}, 32'h0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_pc", if_pc, 32'h0);
      check("rst_instr", if_instr, 32'h0);
      check("rst_pc4", if_pc_plus4, 32'h0);

      // 1: streaming with if_ready = 1
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("t1_addr0", imem_addr, 32'h0);
      check("t1_valid0", {31'h0, if_valid}, 32'h0);
      for (int k = 0; k < 4; k++) begin
         step();
         check("t1_addr", imem_addr, 32'(4 * (k + 1)));
         check("t1_valid", {31'h0, if_valid}, 32'h1);
         check("t1_pc", if_pc, 32'(4 * k));
         check("t1_instr", if_instr, 32'hA000_0000 + 32'(k));
         check("t1_pc4", if_pc_plus4, 32'(4 * k + 4));
      end

      // 2: decode stall saturates the buffer
      rst_n = 1'b0;
      if_ready = 1'b0;
      #3;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 7; k++) step();
      check("t2_addr_hold", imem_addr, 32'h8);
      check("t2_pc_hold", if_pc, 32'h0);
      check("t2_valid", {31'h0, if_valid}, 32'h1);
      if_ready = 1'b1;
      #1;
      check("t2_pop0", if_pc, 32'h0);
      step();
      check("t2_pop1", if_pc, 32'h4);
      check("t2_addr_c", imem_addr, 32'hC);
      step();
      check("t2_pop2", if_pc, 32'h8);
      check("t2_instr2", if_instr, 32'hA000_0002);

      // 3: redirect while full
      if_ready = 1'b0;
      step();
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0043;
      #1;
      check("t3_mask", {31'h0, if_valid}, 32'h0);
      step();
      redirect_valid = 1'b0;
      #1;
      check("t3_addr", imem_addr, 32'h40);
      check("t3_valid_n", {31'h0, if_valid}, 32'h0);
      step();
      check("t3_valid", {31'h0, if_valid}, 32'h1);
      check("t3_pc", if_pc, 32'h40);
      check("t3_instr", if_instr, 32'hA000_0010);

      // 4: redirect to the top word, PC wraps to zero
      if_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      #1;
      check("t4_addr", imem_addr, 32'hFFFF_FFFC);
      step();
      check("t4_pc", if_pc, 32'hFFFF_FFFC);
      check("t4_pc4", if_pc_plus4, 32'h0);
      check("t4_instr", if_instr, 32'hDFFF_FFFF);
      check("t4_addr_wrap", imem_addr, 32'h0);
      step();
      check("t4_pc_wrap", if_pc, 32'h0);
      check("t4_instr_wrap", if_instr, 32'hA000_0000);

      // 5: redirect with ready on a valid head: head is dropped
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0100;
      #1;
      check("t5_mask", {31'h0, if_valid}, 32'h0);
      step();
      redirect_valid = 1'b0;
      step();
      check("t5_pc", if_pc, 32'h100);
      check("t5_instr", if_instr, 32'hA000_0040);
      step();
      check("t5_pc_next", if_pc, 32'h104);

      // 6: asynchronous reset between edges
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_valid", {31'h0, if_valid}, 32'h0);
      check("t6_addr", imem_addr, 32'h0);
      check("t6_pc", if_pc, 32'h0);
      #1;
      rst_n = 1'b1;
      step();
      check("t6_restart_pc", if_pc, 32'h0);
      check("t6_restart_valid", {31'h0, if_valid}, 32'h1);
      check("t6_restart_addr", imem_addr, 32'h4);
      step();
      check("t6_restart_pc1", if_pc, 32'h4);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
